// File: rtl/float2int_pipe_pkg.sv
// Shared float-format constants and stage classification for the float->int converter.
package float2int_pipe_pkg;

    localparam int unsigned DEF_MAN   = 23;
    localparam int unsigned DEF_EXP   = 8;
    localparam int unsigned DEF_OUT_W = 23;

    // NUM covers normals, zeros and flushed subnormals; SAT is Inf or a certain overflow.
    typedef enum logic [1:0] {
        CLS_NUM = 2'd0,
        CLS_SAT = 2'd1,
        CLS_NAN = 2'd2
    } cls_e;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/float2int_pipe_if.sv
// Input float stream and output integer stream of the converter, with their handshakes.
interface float2int_pipe_if #(
    parameter int unsigned MAN   = float2int_pipe_pkg::DEF_MAN,
    parameter int unsigned EXP   = float2int_pipe_pkg::DEF_EXP,
    parameter int unsigned OUT_W = float2int_pipe_pkg::DEF_OUT_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [MAN+EXP:0]     f_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     int_out;
    logic                 ovf;
    logic                 nan;
    logic                 inexact;

    modport master (
        output in_valid, f_in, out_ready,
        input  in_ready, out_valid, int_out, ovf, nan, inexact
    );

    modport slave (
        input  in_valid, f_in, out_ready,
        output in_ready, out_valid, int_out, ovf, nan, inexact
    );
endinterface

// File: rtl/float2int_pipe_rne_round.sv
// Round-to-nearest-even on an unsigned magnitude, apply sign and saturate to the signed range.
module fp_rne_round #(
    parameter int unsigned OUT_W = 23
) (
    input  logic [OUT_W-1:0] mag,
    input  logic             g,
    input  logic             s,
    input  logic             sign,
    output logic [OUT_W-1:0] value_c,
    output logic             ovf_c
);
    localparam logic [OUT_W:0]   LIM_POS = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0]   LIM_NEG = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] INT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [OUT_W:0]   rnd;
    logic [OUT_W-1:0] mag_r;

    // One extra bit keeps the rounding carry visible to the range check.
    assign rnd     = {1'b0, mag} + (OUT_W+1)'(g & (s | mag[0]));
    assign mag_r   = rnd[OUT_W-1:0];
    assign ovf_c   = rnd > (sign ? LIM_NEG : LIM_POS);
    assign value_c = ovf_c ? (sign ? INT_MIN : INT_MAX)
                           : (sign ? (~mag_r + OUT_W'(1)) : mag_r);
endmodule

// File: rtl/float2int_pipe.sv
// 3-stage float -> signed integer converter: classify, align, round/saturate; one common stall enable.
module float2int_pipe
    import float2int_pipe_pkg::*;
#(
    parameter int unsigned MAN   = DEF_MAN,
    parameter int unsigned EXP   = DEF_EXP,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    float2int_pipe_if.slave bus
);
    localparam int unsigned FW  = MAN + EXP + 1;
    localparam int unsigned XW  = MAN + 1 + OUT_W;
    localparam int unsigned SHW = $clog2(OUT_W + 1);
    localparam logic signed [EXP:0] K_BIAS = (EXP+1)'(fp_bias(EXP));
    localparam logic signed [EXP:0] K_NEG1 = '1;
    localparam logic signed [EXP:0] K_ONE  = (EXP+1)'(1);
    localparam logic signed [EXP:0] K_SAT  = (EXP+1)'(OUT_W);
    localparam logic [OUT_W-1:0]    INT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]    INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic                 en;
    logic                 f_sign;
    logic [EXP-1:0]       f_exp;
    logic [MAN-1:0]       f_frac;

    logic                 v1, v2;
    logic                 sign1, zero1, subnz1;
    cls_e                 cls1;
    logic [MAN:0]         m1;
    logic signed [EXP:0]  k1;

    logic                 sign2, g2, s2;
    cls_e                 cls2;
    logic [OUT_W-1:0]     mag2;

    cls_e                 cls2_n;
    logic [OUT_W-1:0]     mag2_n;
    logic                 g2_n, s2_n;
    logic [SHW-1:0]       sh;
    logic [XW-1:0]        x;

    logic [OUT_W-1:0]     rnd_val, int_n;
    logic                 rnd_ovf, ovf_n, nan_n, inex_n;

    assign en          = ~(bus.out_valid & ~bus.out_ready);
    assign bus.in_ready = en;
    assign f_sign      = bus.f_in[FW-1];
    assign f_exp       = bus.f_in[FW-2 -: EXP];
    assign f_frac      = bus.f_in[MAN-1:0];

    // S1: unpack and classify.
    always_ff @(posedge clk) begin
        if (en) begin
            sign1  <= f_sign;
            cls1   <= (&f_exp) ? ((|f_frac) ? CLS_NAN : CLS_SAT) : CLS_NUM;
            zero1  <= (f_exp == '0);
            subnz1 <= (f_exp == '0) && (f_frac != '0);
            m1     <= {(f_exp != '0), f_frac};
            k1     <= $signed({1'b0, f_exp}) - K_BIAS;
        end
    end

    // S2: x = m << (k+1) puts the binary point just above bit MAN, so guard is x[MAN].
    always_comb begin
        cls2_n = cls1;
        mag2_n = '0;
        g2_n   = 1'b0;
        s2_n   = 1'b0;
        sh     = '0;
        x      = '0;
        if (cls1 == CLS_NUM) begin
            if (zero1) begin
                s2_n = subnz1;
            end else if (k1 < K_NEG1) begin
                s2_n = 1'b1;
            end else if (k1 >= K_SAT) begin
                cls2_n = CLS_SAT;
            end else begin
                sh     = SHW'(k1 + K_ONE);
                x      = XW'(m1) << sh;
                mag2_n = x[XW-1 -: OUT_W];
                g2_n   = x[MAN];
                s2_n   = |x[MAN-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sign2 <= sign1;
            cls2  <= cls2_n;
            mag2  <= mag2_n;
            g2    <= g2_n;
            s2    <= s2_n;
        end
    end

    fp_rne_round #(.OUT_W(OUT_W)) u_round (
        .mag     (mag2),
        .g       (g2),
        .s       (s2),
        .sign    (sign2),
        .value_c (rnd_val),
        .ovf_c   (rnd_ovf)
    );

    // S3: special classes override the rounded value; saturated results are never inexact.
    always_comb begin
        int_n  = rnd_val;
        ovf_n  = rnd_ovf;
        nan_n  = 1'b0;
        inex_n = ~rnd_ovf & (g2 | s2);
        case (cls2)
            CLS_NAN: begin
                int_n  = '0;
                ovf_n  = 1'b0;
                nan_n  = 1'b1;
                inex_n = 1'b0;
            end
            CLS_SAT: begin
                int_n  = sign2 ? INT_MIN : INT_MAX;
                ovf_n  = 1'b1;
                inex_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.int_out   <= '0;
            bus.ovf       <= 1'b0;
            bus.nan       <= 1'b0;
            bus.inexact   <= 1'b0;
        end else if (en) begin
            v1            <= bus.in_valid;
            v2            <= v1;
            bus.out_valid <= v2;
            bus.int_out   <= int_n;
            bus.ovf       <= ovf_n;
            bus.nan       <= nan_n;
            bus.inexact   <= inex_n;
        end
    end
endmodule

// File: tb/tb_float2int_pipe.sv
// Self-checking bench for float2int_pipe: directed corner values, backpressure, random stream, reset flush.
module tb_float2int_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float2int_pipe_if bus ();

    float2int_pipe u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [25:0] exp_q[$];
    int          cyc_q[$];
    string       tag_q[$];
    logic        chk_lat    = 1'b0;
    logic        prev_stall = 1'b0;
    logic        last_acc   = 1'b0;
    logic [25:0] prev_out   = '0;

    logic [31:0] dir_f [14] = '{
        32'h3F800000, 32'h40200000, 32'h40600000, 32'hC0200000, 32'h3F000000,
        32'h501502F9, 32'hCA800000, 32'hFF800000, 32'h7FC00000, 32'h80000000,
        32'h00000001, 32'h4A7FFFFF, 32'hCA800001, 32'h7F800000
    };
    logic [25:0] dir_e [14] = '{
        {23'(1), 3'b000}, {23'(2), 3'b001}, {23'(4), 3'b001}, {23'(-2), 3'b001},
        {23'(0), 3'b001}, {23'(4194303), 3'b100}, {23'(-4194304), 3'b000},
        {23'(-4194304), 3'b100}, {23'(0), 3'b010}, {23'(0), 3'b000},
        {23'(0), 3'b001}, {23'(4194303), 3'b100}, {23'(-4194304), 3'b001},
        {23'(4194303), 3'b100}
    };
    logic [31:0] bp_f [8] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference: exact value m * 2^(e-150), rounded by remainder vs. half, then range-limited.
    function automatic logic [25:0] model(input logic [31:0] f);
        logic   s, ovf, nan, inx;
        int     e, k, sh;
        longint m, mag, rem, half, val;
        s = f[31]; e = int'(f[30:23]); m = longint'(f[22:0]);
        ovf = 1'b0; nan = 1'b0; inx = 1'b0; val = 0;
        if (e == 255) begin
            if (m != 0) nan = 1'b1;
            else begin ovf = 1'b1; val = s ? -4194304 : 4194303; end
        end else if (e == 0) begin
            inx = (m != 0);
        end else begin
            m = m + (64'sd1 << 23);
            k = e - 127;
            if (k >= 31) begin
                ovf = 1'b1; val = s ? -4194304 : 4194303;
            end else begin
                if (k >= 23) begin
                    mag = m << (k - 23); rem = 0;
                end else begin
                    sh = 23 - k;
                    if (sh >= 40) begin
                        mag = 0; rem = 1;
                    end else begin
                        mag  = m >> sh;
                        rem  = m - (mag << sh);
                        half = 64'sd1 << (sh - 1);
                        if (rem > half || (rem == half && (mag % 2) == 1)) mag = mag + 1;
                    end
                end
                inx = (rem != 0);
                val = s ? -mag : mag;
                if (val > 4194303 || val < -4194304) begin
                    ovf = 1'b1; inx = 1'b0; val = s ? -4194304 : 4194303;
                end
            end
        end
        return {23'(val), ovf, nan, inx};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int sel;
        sel = int'($urandom_range(0, 9));
        f = $urandom;
        case (sel)
            0: f[30:23] = 8'd0;
            1: f[30:23] = 8'd255;
            2: ;
            3: begin f[30:23] = 8'($urandom_range(120, 150)); f[22:0] = f[22:0] & 23'h7FF000; end
            default: f[30:23] = 8'($urandom_range(110, 160));
        endcase
        return f;
    endfunction

    task automatic step(input logic iv, input logic [31:0] f, input logic ordy,
                        input string tag, input logic use_exp, input logic [25:0] expv);
        logic [25:0] obs;
        @(negedge clk);
        cyc++;
        bus.in_valid  = iv;
        bus.f_in      = f;
        bus.out_ready = ordy;
        #1;
        obs = {bus.int_out, bus.ovf, bus.nan, bus.inexact};
        if (prev_stall) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_data", 64'(obs), 64'(prev_out));
        end
        prev_stall = rst_n & bus.out_valid & ~bus.out_ready;
        prev_out   = obs;
        if (prev_stall) check("in_ready_stall", 64'(bus.in_ready), 64'd0);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                string       t;
                int          c;
                logic [25:0] e;
                t = tag_q.pop_front();
                c = cyc_q.pop_front();
                e = exp_q.pop_front();
                check(t, 64'(obs), 64'(e));
                if (chk_lat) check("latency", 64'(cyc - c), 64'd3);
            end
        end
        last_acc = rst_n & bus.in_valid & bus.in_ready;
        if (last_acc) begin
            exp_q.push_back(use_exp ? expv : model(f));
            cyc_q.push_back(cyc);
            tag_q.push_back(tag);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, "drain", 1'b0, '0);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        bus.in_valid  = 1'b0;
        bus.f_in      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_outputs", 64'({bus.int_out, bus.ovf, bus.nan, bus.inexact}), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;

        chk_lat = 1'b1;
        foreach (dir_f[i]) step(1'b1, dir_f[i], 1'b1, $sformatf("dir%0d", i), 1'b1, dir_e[i]);
        drain();
        chk_lat = 1'b0;

        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            step(1'b1, bp_f[idx], !(c >= 4 && c < 8), $sformatf("bp%0d", idx + 1), 1'b1,
                 {23'(idx + 1), 3'b000});
            if (last_acc) idx++;
        end
        check("bp_all_accepted", 64'(idx), 64'd8);
        drain();

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, rand_float(), $urandom_range(0, 9) < 7, "rnd", 1'b0, '0);
        drain();

        for (int i = 0; i < 3; i++) step(1'b1, bp_f[i], 1'b1, "flushed", 1'b0, '0);
        step(1'b0, '0, 1'b0, "flushed", 1'b0, '0);
        rst_n = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete(); cyc_q.delete(); tag_q.delete();
        step(1'b0, '0, 1'b1, "rst", 1'b0, '0);
        check("rst_flush_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, "idle", 1'b0, '0);
            check("post_rst_idle", 64'(bus.out_valid), 64'd0);
        end
        chk_lat = 1'b1;
        step(1'b1, 32'h40600000, 1'b1, "post_rst_3p5", 1'b1, {23'(4), 3'b001});
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
